// File: rtl/writeback_queue.sv
// Writeback queue: funnels two execution writeback ports into one register-file write port.
// Optional feature macro WBQ_BYPASS_EN: an empty queue forwards the oldest new write straight to the output.
module writeback_queue #(
    parameter int regWidth  = 5,
    parameter int dataWidth = 64,
    parameter int DEPTH     = 8
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   reg1WritebackEnable_i,
    input  logic                   reg2WritebackEnable_i,
    input  logic [regWidth-1:0]    reg1WritebackAddress_i,
    input  logic [regWidth-1:0]    reg2WritebackAddress_i,
    input  logic [dataWidth-1:0]   reg1WritebackVal_i,
    input  logic [dataWidth-1:0]   reg2WritebackVal_i,
    input  logic                   condRegUpdateEnable_i,
    input  logic [31:0]            newCRVal_i,
    output logic                   stall_o,
    output logic                   wbEnable_o,
    output logic [regWidth-1:0]    wbAddress_o,
    output logic [dataWidth-1:0]   wbVal_o,
    output logic                   crWriteEnable_o,
    output logic [31:0]            crVal_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
);
    localparam int AW          = $clog2(DEPTH);
    localparam int CW          = AW + 1;
    localparam int CW1         = CW + 1;
    localparam int EW          = regWidth + dataWidth;
    localparam int STALL_LIMIT = DEPTH - 2;
    localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];
    localparam logic [CW-1:0] STALL_W = STALL_LIMIT[CW-1:0];

    logic [EW-1:0]        mem_r [DEPTH];
    logic [AW-1:0]        rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s, wr_ptr_inc_s;
    logic [CW-1:0]        count_r, count_nxt_s;
    logic                 wb_en_r, wb_en_nxt_s;
    logic [regWidth-1:0]  wb_addr_r, wb_addr_nxt_s;
    logic [dataWidth-1:0] wb_val_r, wb_val_nxt_s;
    logic                 cr_en_r, cr_en_nxt_s;
    logic [31:0]          cr_val_r, cr_val_nxt_s;
    logic                 overflow_r, overflow_nxt_s;
    logic                 deq_s, bypass_s, drop_s, mem_we0_s, mem_we1_s;
    logic [1:0]           req_cnt_s, enq_cnt_s;
    logic [CW:0]          free_s;
    logic [EW-1:0]        first_ent_s, second_ent_s, enq0_ent_s, head_ent_s;

    // Request decode: order the new writes, decide bypass and whether they fit.
    always_comb begin
        req_cnt_s = {1'b0, reg1WritebackEnable_i} + {1'b0, reg2WritebackEnable_i};
        if (reg1WritebackEnable_i) begin
            first_ent_s = {reg1WritebackAddress_i, reg1WritebackVal_i};
        end else begin
            first_ent_s = {reg2WritebackAddress_i, reg2WritebackVal_i};
        end
        second_ent_s = {reg2WritebackAddress_i, reg2WritebackVal_i};
        deq_s        = (count_r != {CW{1'b0}});
`ifdef WBQ_BYPASS_EN
        bypass_s = !deq_s && (req_cnt_s != 2'd0);
`else
        bypass_s = 1'b0;
`endif
        if (bypass_s) begin
            enq_cnt_s  = req_cnt_s - 2'd1;
            enq0_ent_s = second_ent_s;
        end else begin
            enq_cnt_s  = req_cnt_s;
            enq0_ent_s = first_ent_s;
        end
        // Slots freed by this edge's dequeue are usable by this edge's writes.
        free_s       = DEPTH_W - {1'b0, count_r} + CW1'(deq_s);
        drop_s       = (CW1'(enq_cnt_s) > free_s);
        head_ent_s   = mem_r[rd_ptr_r];
        wr_ptr_inc_s = wr_ptr_r + AW'(1'b1);
    end

    // Next-state: flush wins over everything, overflowing writes are dropped whole.
    always_comb begin
        count_nxt_s    = count_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        wr_ptr_nxt_s   = wr_ptr_r;
        wb_en_nxt_s    = 1'b0;
        wb_addr_nxt_s  = wb_addr_r;
        wb_val_nxt_s   = wb_val_r;
        cr_en_nxt_s    = 1'b0;
        cr_val_nxt_s   = cr_val_r;
        overflow_nxt_s = overflow_r;
        mem_we0_s      = 1'b0;
        mem_we1_s      = 1'b0;
        if (flush_i) begin
            count_nxt_s  = {CW{1'b0}};
            rd_ptr_nxt_s = {AW{1'b0}};
            wr_ptr_nxt_s = {AW{1'b0}};
        end else begin
            if (bypass_s) begin
                wb_en_nxt_s                  = 1'b1;
                {wb_addr_nxt_s, wb_val_nxt_s} = first_ent_s;
            end else if (deq_s) begin
                wb_en_nxt_s                  = 1'b1;
                {wb_addr_nxt_s, wb_val_nxt_s} = head_ent_s;
            end else begin
                wb_en_nxt_s = 1'b0;
            end
            if (drop_s) begin
                overflow_nxt_s = 1'b1;
                count_nxt_s    = count_r - CW'(deq_s);
            end else begin
                mem_we0_s    = (enq_cnt_s != 2'd0);
                mem_we1_s    = (enq_cnt_s == 2'd2);
                count_nxt_s  = count_r + CW'(enq_cnt_s) - CW'(deq_s);
                wr_ptr_nxt_s = wr_ptr_r + AW'(enq_cnt_s);
            end
            rd_ptr_nxt_s = rd_ptr_r + AW'(deq_s);
            cr_en_nxt_s  = condRegUpdateEnable_i;
            cr_val_nxt_s = newCRVal_i;
        end
    end

    // Storage array: no reset, entries beyond the read pointer are never observed.
    always_ff @(posedge clock_i) begin
        if (mem_we0_s) begin
            mem_r[wr_ptr_r] <= enq0_ent_s;
        end
        if (mem_we1_s) begin
            mem_r[wr_ptr_inc_s] <= second_ent_s;
        end
    end

    // Control and output registers.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            count_r    <= {CW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            wb_en_r    <= 1'b0;
            wb_addr_r  <= {regWidth{1'b0}};
            wb_val_r   <= {dataWidth{1'b0}};
            cr_en_r    <= 1'b0;
            cr_val_r   <= 32'd0;
            overflow_r <= 1'b0;
        end else begin
            count_r    <= count_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            wb_en_r    <= wb_en_nxt_s;
            wb_addr_r  <= wb_addr_nxt_s;
            wb_val_r   <= wb_val_nxt_s;
            cr_en_r    <= cr_en_nxt_s;
            cr_val_r   <= cr_val_nxt_s;
            overflow_r <= overflow_nxt_s;
        end
    end

    assign stall_o         = (count_r > STALL_W);
    assign wbEnable_o      = wb_en_r;
    assign wbAddress_o     = wb_addr_r;
    assign wbVal_o         = wb_val_r;
    assign crWriteEnable_o = cr_en_r;
    assign crVal_o         = cr_val_r;
    assign count_o         = count_r;
    assign overflow_o      = overflow_r;

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_writeback_queue;
    localparam int RW    = 5;
    localparam int DW    = 64;
    localparam int DEPTH = 8;
`ifdef WBQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clock_i = 1'b0;
    logic          reset_i, flush_i;
    logic          reg1WritebackEnable_i, reg2WritebackEnable_i;
    logic [RW-1:0] reg1WritebackAddress_i, reg2WritebackAddress_i;
    logic [DW-1:0] reg1WritebackVal_i, reg2WritebackVal_i;
    logic          condRegUpdateEnable_i;
    logic [31:0]   newCRVal_i;
    logic          stall_o, wbEnable_o, crWriteEnable_o, overflow_o;
    logic [RW-1:0] wbAddress_o;
    logic [DW-1:0] wbVal_o;
    logic [31:0]   crVal_o;
    logic [3:0]    count_o;

    writeback_queue #(.regWidth(RW), .dataWidth(DW), .DEPTH(DEPTH)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i),
        .reg1WritebackEnable_i(reg1WritebackEnable_i), .reg2WritebackEnable_i(reg2WritebackEnable_i),
        .reg1WritebackAddress_i(reg1WritebackAddress_i), .reg2WritebackAddress_i(reg2WritebackAddress_i),
        .reg1WritebackVal_i(reg1WritebackVal_i), .reg2WritebackVal_i(reg2WritebackVal_i),
        .condRegUpdateEnable_i(condRegUpdateEnable_i), .newCRVal_i(newCRVal_i),
        .stall_o(stall_o), .wbEnable_o(wbEnable_o), .wbAddress_o(wbAddress_o), .wbVal_o(wbVal_o),
        .crWriteEnable_o(crWriteEnable_o), .crVal_o(crVal_o), .count_o(count_o), .overflow_o(overflow_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct packed {
        logic [RW-1:0] a;
        logic [DW-1:0] v;
    } ent_t;

    // Reference model state
    ent_t          q[$];
    logic          m_en, m_cr_en, m_ovf;
    logic [RW-1:0] m_addr;
    logic [DW-1:0] m_val;
    logic [31:0]   m_cr_val;

    int  pass_cnt  = 0;
    int  total_cnt = 0;
    bit  chk_on    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_en = 1'b0; m_addr = '0; m_val = '0;
        m_cr_en = 1'b0; m_cr_val = '0; m_ovf = 1'b0;
    endtask

    // One clock edge of the specified behaviour, using the inputs present at that edge.
    task automatic model_step();
        ent_t reqs[$];
        ent_t e;
        if (flush_i) begin
            q.delete();
            m_en = 1'b0;
            m_cr_en = 1'b0;
        end else begin
            if (reg1WritebackEnable_i) begin
                e.a = reg1WritebackAddress_i; e.v = reg1WritebackVal_i; reqs.push_back(e);
            end
            if (reg2WritebackEnable_i) begin
                e.a = reg2WritebackAddress_i; e.v = reg2WritebackVal_i; reqs.push_back(e);
            end
            if (BYP && q.size() == 0 && reqs.size() > 0) begin
                e = reqs.pop_front(); m_en = 1'b1; m_addr = e.a; m_val = e.v;
            end else if (q.size() > 0) begin
                e = q.pop_front(); m_en = 1'b1; m_addr = e.a; m_val = e.v;
            end else begin
                m_en = 1'b0;
            end
            if (reqs.size() > DEPTH - q.size()) m_ovf = 1'b1;
            else foreach (reqs[i]) q.push_back(reqs[i]);
            m_cr_en  = condRegUpdateEnable_i;
            m_cr_val = newCRVal_i;
        end
    endtask

    task automatic drive(input logic f, input logic e1, input logic [RW-1:0] a1, input logic [DW-1:0] v1,
                         input logic e2, input logic [RW-1:0] a2, input logic [DW-1:0] v2,
                         input logic ce, input logic [31:0] cv);
        flush_i = f;
        reg1WritebackEnable_i = e1; reg1WritebackAddress_i = a1; reg1WritebackVal_i = v1;
        reg2WritebackEnable_i = e2; reg2WritebackAddress_i = a2; reg2WritebackVal_i = v2;
        condRegUpdateEnable_i = ce; newCRVal_i = cv;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clock_i);
        model_step();
        @(negedge clock_i);
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clock_i) begin
        if (chk_on && reset_i) begin
            check("count", 64'(count_o), 64'(q.size()));
            check("stall", 64'(stall_o), 64'(q.size() > DEPTH - 2));
            check("overflow", 64'(overflow_o), 64'(m_ovf));
            check("wb_en", 64'(wbEnable_o), 64'(m_en));
            if (m_en) begin
                check("wb_addr", 64'(wbAddress_o), 64'(m_addr));
                check("wb_val", wbVal_o, m_val);
            end
            check("cr_en", 64'(crWriteEnable_o), 64'(m_cr_en));
            if (m_cr_en) check("cr_val", 64'(crVal_o), 64'(m_cr_val));
        end
    end

    initial begin
        reset_i = 1'b0;
        idle();
        model_reset();
        repeat (3) @(negedge clock_i);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_wb_en", 64'(wbEnable_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        reset_i = 1'b1;
        chk_on  = 1'b1;

        // Dual write into an empty queue: r3 then r4.
        drive(1'b0, 1'b1, 5'd3, 64'h11, 1'b1, 5'd4, 64'h22, 1'b0, 32'd0);
        tick();
        idle();
`ifndef WBQ_BYPASS_EN
        check("t1_count_k", 64'(count_o), 64'd2);
        check("t1_en_k", 64'(wbEnable_o), 64'd0);
        tick();
        check("t1_en_k1", 64'(wbEnable_o), 64'd1);
        check("t1_addr_k1", 64'(wbAddress_o), 64'd3);
        check("t1_val_k1", wbVal_o, 64'h11);
        check("t1_count_k1", 64'(count_o), 64'd1);
        tick();
        check("t1_addr_k2", 64'(wbAddress_o), 64'd4);
        check("t1_val_k2", wbVal_o, 64'h22);
        check("t1_count_k2", 64'(count_o), 64'd0);
`endif
        repeat (3) tick();

        // Sustained dual writes up to full, then one that must overflow.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 5'(i), 64'(100 + i), 1'b1, 5'(i + 8), 64'(200 + i), 1'b0, 32'd0);
            tick();
`ifndef WBQ_BYPASS_EN
            if (i < 7) check("t2_count", 64'(count_o), 64'(i + 2));
            else       check("t2_count_drop", 64'(count_o), 64'd7);
            check("t2_stall", 64'(stall_o), 64'(i >= 5));
            check("t2_ovf", 64'(overflow_o), 64'(i == 7));
`endif
        end
        idle();
        repeat (2) tick();
`ifndef WBQ_BYPASS_EN
        check("t3_count_pre", 64'(count_o), 64'd5);
`endif
        // Flush with a concurrent reg1 write.
        drive(1'b1, 1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'd0, 1'b0, 32'd0);
        tick();
        check("t3_count", 64'(count_o), 64'd0);
        check("t3_en", 64'(wbEnable_o), 64'd0);
        idle();
        tick();
        check("t3_en_next", 64'(wbEnable_o), 64'd0);
        check("t3_ovf_sticky", 64'(overflow_o), 64'(!BYP));

        // Condition-register path.
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 32'hDEADBEEF);
        tick();
        check("cr_en", 64'(crWriteEnable_o), 64'd1);
        check("cr_val", 64'(crVal_o), 64'hDEADBEEF);
        idle();
        tick();
        check("cr_en_drop", 64'(crWriteEnable_o), 64'd0);

`ifdef WBQ_BYPASS_EN
        drive(1'b0, 1'b1, 5'd7, 64'hABCD, 1'b0, 5'd0, 64'd0, 1'b0, 32'd0);
        tick();
        check("byp_en", 64'(wbEnable_o), 64'd1);
        check("byp_addr", 64'(wbAddress_o), 64'd7);
        check("byp_val", wbVal_o, 64'hABCD);
        check("byp_count", 64'(count_o), 64'd0);
        idle();
        tick();
`endif

        // Asynchronous reset in the middle of traffic.
        drive(1'b0, 1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2, 1'b0, 32'd0);
        tick();
        drive(1'b0, 1'b1, 5'd5, 64'h5, 1'b1, 5'd6, 64'h6, 1'b1, 32'h1234);
        tick();
`ifndef WBQ_BYPASS_EN
        check("t5_count_pre", 64'(count_o), 64'd3);
`endif
        check("t5_cr_pre", 64'(crWriteEnable_o), 64'd1);
        idle();
        #3 reset_i = 1'b0;
        #1;
        check("t5_count", 64'(count_o), 64'd0);
        check("t5_en", 64'(wbEnable_o), 64'd0);
        check("t5_addr", 64'(wbAddress_o), 64'd0);
        check("t5_val", wbVal_o, 64'd0);
        check("t5_cr_en", 64'(crWriteEnable_o), 64'd0);
        check("t5_cr_val", 64'(crVal_o), 64'd0);
        check("t5_ovf", 64'(overflow_o), 64'd0);
        check("t5_stall", 64'(stall_o), 64'd0);
        model_reset();
        @(negedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b1;
        tick();
        check("t5_no_write_after_release", 64'(wbEnable_o), 64'd0);

        // Random traffic, mostly honouring the stall signal.
        for (int n = 0; n < 3000; n++) begin
            logic e1, e2;
            e1 = ($urandom_range(0, 1) == 1);
            e2 = ($urandom_range(0, 1) == 1);
            if (q.size() > DEPTH - 2 && $urandom_range(0, 9) != 0) begin
                e1 = 1'b0; e2 = 1'b0;
            end
            drive(($urandom_range(0, 49) == 0), e1, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                  e2, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                  ($urandom_range(0, 1) == 1), $urandom);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter regWidth, default 5, GPR address width.
REQ-002 SHALL have parameter dataWidth, default 64, writeback value width.
REQ-003 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, >=4).
REQ-004 SHALL have port clock_i  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port reset_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i  input  1  discard all queued and output writes.
REQ-007 SHALL have ports reg1WritebackEnable_i, reg2WritebackEnable_i  input  1 each  write request from execution writeback.
REQ-008 SHALL have ports reg1WritebackAddress_i, reg2WritebackAddress_i  input  regWidth each  target GPR.
REQ-009 SHALL have ports reg1WritebackVal_i, reg2WritebackVal_i  input  dataWidth each  write data.
REQ-010 SHALL have ports condRegUpdateEnable_i  input  1 and newCRVal_i  input  32 (bits 32:63)  CR update.
REQ-011 SHALL have ports stall_o  output  1  upstream must not present writes.
REQ-012 SHALL have ports wbEnable_o  output  1, wbAddress_o  output  regWidth, wbVal_o  output  dataWidth  single register-file write port.
REQ-013 SHALL have ports crWriteEnable_o  output  1 and crVal_o  output  32  CR write.
REQ-014 SHALL have ports count_o  output  log2(DEPTH)+1  FIFO occupancy, and overflow_o  output  1  sticky overflow flag.

Function
REQ-015 SHALL enqueue reg1 then reg2 in one cycle when both enabled; reg1 occupies the lower-order (older) slot.
REQ-016 SHALL enqueue only the enabled port when one enable is set; no slot consumed for a disabled port.
REQ-017 SHALL load the FIFO head into wbAddress_o/wbVal_o with wbEnable_o=1 on every edge the FIFO is non-empty, else wbEnable_o=0; one write drained per cycle, register file never backpressures.
REQ-018 SHALL give enqueue-to-output latency of 2 edges when the macro of REQ-029 is undefined (capture at edge k, output valid after edge k+1).
REQ-019 SHALL update count_o as count + enqueued - dequeued each edge; simultaneous enqueue of 2 and dequeue of 1 nets +1.
REQ-020 SHALL drive stall_o combinationally high when count_o > DEPTH-2 (fewer than two free slots).
REQ-021 SHALL, when writes arrive with insufficient free slots (after same-cycle dequeue), drop the whole cycle's writes, leave FIFO unchanged, set overflow_o to 1 until reset.
REQ-022 SHALL wrap read/write pointers modulo DEPTH; full = count_o==DEPTH, empty = count_o==0.
REQ-023 SHALL register condRegUpdateEnable_i/newCRVal_i to crWriteEnable_o/crVal_o with 1-edge latency, independent of FIFO; crWriteEnable_o low the following cycle unless re-asserted.
REQ-024 SHALL, on flush_i at an edge, set count_o=0, pointers 0, wbEnable_o=0, crWriteEnable_o=0 and ignore that cycle's inputs; flush has priority over enqueue, dequeue and bypass; overflow_o unaffected.
REQ-025 SHALL preserve program order for writes to the same address (later queued write reaches wbEnable_o later).

Reset
REQ-026 SHALL, while reset_i=0, asynchronously force count_o=0, pointers 0, wbEnable_o=0, wbAddress_o=0, wbVal_o=0, crWriteEnable_o=0, crVal_o=0, overflow_o=0; stall_o therefore 0.
REQ-027 SHALL discard in-flight FIFO contents on reset assertion mid-operation; no write issued on the first edge after release unless enqueued (bypass) on that edge.
REQ-028 SHALL NOT require FIFO storage array reset; unread entries are don't-care.

Configuration
REQ-029 SHALL, with WBQ_BYPASS_EN defined, load reg1 (or sole enabled port) directly into the output register on the capture edge when FIFO empty, enqueueing only reg2; latency 1 edge.
REQ-030 SHALL, without WBQ_BYPASS_EN, route all writes through the FIFO (REQ-018); flush still overrides bypass.

Verification
REQ-031 SHALL cover: reg1 (r3,0x11) and reg2 (r4,0x22) same cycle, empty queue, no bypass -> wbEnable_o r3/0x11 after edge k+1, r4/0x22 after k+2, count_o 2,1,0.
REQ-032 SHALL cover: DEPTH=8, dual writes 4 consecutive cycles -> count_o 2,3,4,5 after first dequeue overlap; stall_o high once count_o=7; no overflow.
REQ-033 SHALL cover: dual write presented with count_o=8 and same-cycle dequeue -> writes dropped, count_o=7, overflow_o=1 sticky until reset_i low.
REQ-034 SHALL cover: flush_i with count_o=5 and simultaneous reg1 write -> count_o=0, wbEnable_o=0 next cycle, input not written.
REQ-035 SHALL cover: WBQ_BYPASS_EN, empty queue, single reg1 write (r7,0xABCD) -> wbEnable_o r7/0xABCD after edge k, count_o stays 0.
REQ-036 SHALL cover: reset_i pulsed low mid-stream (count_o=3, crWriteEnable_o=1) -> all outputs 0 immediately without clock edge.
